// File: rtl/io_pkg.sv
// Shared types and sizing helpers for the io_uart_bridge GPIO/UART block.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full pushes and empty pops are ignored.
module io_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_bridge.sv
// Board I/O bridge: synchronised switches to LEDs, FIFO-buffered UART transmitter and
// a UART receiver with start-bit glitch rejection and framing-error reporting.
module io_uart_bridge
  import io_pkg::*;
#(
  parameter int GPIO_W       = 8,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] switches,
  output logic [GPIO_W-1:0] leds,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              uart_tx,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_frame_err
);

  localparam int BAUD_W   = baud_cnt_w(CLKS_PER_BIT);
  localparam int BIT_W    = bit_cnt_w(DATA_W);
  localparam int HALF_BIT = half_bit(CLKS_PER_BIT);
  localparam int CNT_W    = $clog2(TX_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  // GPIO: two synchroniser stages, then the LED register.
  logic [GPIO_W-1:0] sw_meta, sw_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
      leds    <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
      leds    <= sw_sync;
    end
  end

  // ---------------- TX path ----------------
  uart_state_t       tx_state, tx_state_n;
  logic [BAUD_W-1:0] tx_baud, tx_baud_n;
  logic [BIT_W-1:0]  tx_bit, tx_bit_n;
  logic [DATA_W-1:0] tx_shift, tx_shift_n;
  logic              tx_line, tx_line_n;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;

  io_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_valid),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (tx_state != IDLE) || (fifo_count != '0);
  assign uart_tx  = tx_line;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_line  <= tx_line_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_baud + BAUD_ONE;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    fifo_pop   = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_baud_n = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_n = fifo_rdata;
          tx_line_n  = 1'b0;
          tx_state_n = START;
        end
      end
      START: if (tx_baud == BAUD_LAST) begin
        tx_baud_n  = '0;
        tx_bit_n   = '0;
        tx_line_n  = tx_shift[0];
        tx_state_n = DATA;
      end
      DATA: if (tx_baud == BAUD_LAST) begin
        tx_baud_n = '0;
        if (tx_bit == BIT_LAST) begin
          tx_line_n  = 1'b1;
          tx_state_n = STOP;
        end else begin
          tx_bit_n   = tx_bit + BIT_ONE;
          tx_shift_n = tx_shift >> 1;
          tx_line_n  = tx_shift[1];
        end
      end
      STOP: if (tx_baud == BAUD_LAST) begin
        tx_baud_n = '0;
        // Chain straight into the next start bit so buffered bytes leave with no idle gap.
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_n = fifo_rdata;
          tx_line_n  = 1'b0;
          tx_state_n = START;
        end else begin
          tx_state_n = IDLE;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  logic              rx_meta, rxs, rxs_q;
  uart_state_t       rx_state, rx_state_n;
  logic [BAUD_W-1:0] rx_baud, rx_baud_n;
  logic [BIT_W-1:0]  rx_bit, rx_bit_n;
  logic [DATA_W-1:0] rx_shift, rx_shift_n, rx_data_n;
  logic              rx_valid_n, rx_frame_err_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta      <= 1'b1;
      rxs          <= 1'b1;
      rxs_q        <= 1'b1;
      rx_state     <= IDLE;
      rx_baud      <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta      <= uart_rx;
      rxs          <= rx_meta;
      rxs_q        <= rxs;
      rx_state     <= rx_state_n;
      rx_baud      <= rx_baud_n;
      rx_bit       <= rx_bit_n;
      rx_shift     <= rx_shift_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rx_frame_err <= rx_frame_err_n;
    end
  end

  always_comb begin
    rx_state_n     = rx_state;
    rx_baud_n      = rx_baud + BAUD_ONE;
    rx_bit_n       = rx_bit;
    rx_shift_n     = rx_shift;
    rx_data_n      = rx_data;
    rx_valid_n     = 1'b0;
    rx_frame_err_n = 1'b0;
    unique case (rx_state)
      IDLE: begin
        rx_baud_n = '0;
        // Arming needs a high-to-low transition, so a line stuck low after a break never retriggers.
        if (rxs_q && !rxs) rx_state_n = START;
      end
      START: if (rx_baud == HALF_LAST) begin
        rx_baud_n  = '0;
        rx_bit_n   = '0;
        rx_state_n = rxs ? IDLE : DATA;
      end
      DATA: if (rx_baud == BAUD_LAST) begin
        rx_baud_n  = '0;
        rx_shift_n = {rxs, rx_shift[DATA_W-1:1]};
        if (rx_bit == BIT_LAST) rx_state_n = STOP;
        else                    rx_bit_n   = rx_bit + BIT_ONE;
      end
      STOP: if (rx_baud == BAUD_LAST) begin
        rx_baud_n  = '0;
        rx_state_n = IDLE;
        if (rxs) begin
          rx_data_n  = rx_shift;
          rx_valid_n = 1'b1;
        end else begin
          rx_frame_err_n = 1'b1;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_uart_bridge.sv
// Scoreboard bench for io_uart_bridge: stimulus queues expected bytes, independent monitors
// decode the serial line and the RX outputs and compare against those queues.
module tb_io_uart_bridge;

  localparam int GPIO_W = 8;
  localparam int DATA_W = 8;
  localparam int CPB    = 16;
  localparam int DEPTH  = 4;
  localparam int FRAME  = (DATA_W + 2) * CPB;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [GPIO_W-1:0] switches = '0;
  logic [GPIO_W-1:0] leds;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready, tx_busy, uart_tx, uart_rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, rx_frame_err;
  logic              loopback = 1'b1;
  logic              rx_drive = 1'b1;

  assign uart_rx = loopback ? uart_tx : rx_drive;

  io_uart_bridge #(
    .GPIO_W       (GPIO_W),
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CPB),
    .TX_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .switches     (switches),
    .leds         (leds),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .uart_tx      (uart_tx),
    .uart_rx      (uart_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int         start_times[$];
  int         err_pending = 0;
  logic [7:0] last_rx = '0;
  int         rx_valid_seen = 0;
  int         rx_err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial frame as a bit list: start(0), data LSB first, stop(1).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DATA_W) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int g;
    g = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) check("push_accept_timeout", tx_ready, 1);
    tx_exp.push_back(b);
    if (loopback) rx_exp.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit);
    for (int idx = 0; idx < DATA_W + 2; idx++) begin
      rx_drive = (idx == DATA_W + 1) ? stop_bit : frame_bit(b, idx);
      tick(CPB);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int g;
    g = 0;
    while (!(tx_busy === 1'b0 && tx_exp.size() == 0 && rx_exp.size() == 0) && g < limit) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_drained"}, g < limit, 1);
  endtask

  // Line monitor: every frame must match its queued byte cycle by cycle for the full frame.
  initial begin : tx_monitor
    logic [7:0] b;
    int         bad_at;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        start_times.push_back(cyc);
        check("tx_frame_expected", tx_exp.size() > 0, 1);
        b = (tx_exp.size() > 0) ? tx_exp.pop_front() : 8'h00;
        bad_at  = -1;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (bad_at < 0 && uart_tx !== frame_bit(b, k / CPB)) bad_at = k;
        end
        if (!aborted) check($sformatf("tx_frame_%02h_first_bad_cycle", b), bad_at, -1);
      end
    end
  end

  // RX monitor: received bytes and framing errors against what stimulus predicted.
  initial begin : rx_monitor
    bit         prev_v;
    bit         prev_e;
    logic [7:0] e;
    prev_v = 1'b0;
    prev_e = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        check("rx_valid_single_cycle", prev_v, 0);
        if (!prev_v) begin
          rx_valid_seen++;
          check("rx_valid_expected", rx_exp.size() > 0, 1);
          if (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            check("rx_data", rx_data, e);
            last_rx = e;
          end
        end
      end
      if (rx_frame_err === 1'b1) begin
        check("rx_frame_err_single_cycle", prev_e, 0);
        if (!prev_e) begin
          rx_err_seen++;
          check("rx_frame_err_expected", err_pending > 0, 1);
          if (err_pending > 0) err_pending--;
          check("rx_data_held_on_err", rx_data, last_rx);
        end
      end
      prev_v = (rx_valid === 1'b1);
      prev_e = (rx_frame_err === 1'b1);
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] sw_prev, sw_new;
    int         g, base_v, base_e;

    // Reset held with pushes and switches active.
    rst_n    = 1'b0;
    switches = 8'hAA;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_leds", leds, 8'h00);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_tx_ready", tx_ready, 1);
    end
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_frame_err", rx_frame_err, 0);
    rst_n    = 1'b1;
    tx_valid = 1'b0;
    switches = 8'hCC;
    tick();  // capture edge
    check("leds_after_capture", leds, 8'h00);
    tick();
    check("leds_capture_plus1", leds, 8'h00);
    tick();
    check("leds_capture_plus2", leds, 8'hCC);
    tick(30);
    check("no_frame_from_reset_push", start_times.size(), 0);
    check("idle_tx_busy", tx_busy, 0);

    sw_prev = 8'hCC;
    for (int i = 0; i < 4; i++) begin
      sw_new   = 8'($urandom);
      switches = sw_new;
      tick(2);
      check("leds_rand_hold", leds, sw_prev);
      tick();
      check("leds_rand_update", leds, sw_new);
      sw_prev = sw_new;
    end

    // Single byte: latency, frame shape, receive latency.
    start_times.delete();
    push_byte(8'h55);
    check("tx_high_at_push_edge", uart_tx, 1);
    tick();
    check("tx_low_one_edge_after_pop", uart_tx, 0);
    g = 0;
    while (rx_valid !== 1'b1 && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("rx_55_latency_le_156", (start_times.size() > 0) && (cyc - start_times[0] <= 156), 1);
    wait_idle("single_55", 400);

    // Back-to-back burst fills the FIFO; a sixth byte waits for space.
    start_times.delete();
    push_byte(8'hA7);
    push_byte(8'h01);
    push_byte(8'hFF);
    push_byte(8'h3C);
    push_byte(8'h80);
    check("tx_ready_low_when_full", tx_ready, 0);
    push_byte(8'h5A);
    g = 0;
    while (tx_busy !== 1'b0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("burst_frame_count", start_times.size(), 6);
    if (start_times.size() == 6) begin
      for (int i = 1; i < 6; i++)
        check($sformatf("burst_gap_%0d", i), start_times[i] - start_times[i-1], FRAME);
      check("tx_busy_fall_at_frame_end", cyc - start_times[5], FRAME);
    end
    wait_idle("burst", 400);

    // Open loop: short low glitch must produce nothing.
    loopback = 1'b0;
    rx_drive = 1'b1;
    tick(5);
    base_v = rx_valid_seen;
    base_e = rx_err_seen;
    rx_drive = 1'b0;
    tick(5);
    rx_drive = 1'b1;
    tick(60);
    check("glitch_no_rx_event", (rx_valid_seen - base_v) + (rx_err_seen - base_e), 0);

    // Framing error with a break, then a clean frame.
    err_pending++;
    send_rx_frame(8'h3C, 1'b0);
    tick(30);
    check("frame_err_seen", rx_err_seen - base_e, 1);
    check("frame_err_no_valid", rx_valid_seen - base_v, 0);
    check("frame_err_rx_data_kept", rx_data, 8'h5A);
    rx_drive = 1'b1;
    tick(20);
    rx_exp.push_back(8'h12);
    send_rx_frame(8'h12, 1'b1);
    tick(20);
    check("after_err_valid_seen", rx_valid_seen - base_v, 1);
    check("after_err_rx_data", rx_data, 8'h12);

    // Reset in the middle of a frame.
    loopback = 1'b1;
    tick(5);
    start_times.delete();
    push_byte(8'hF0);
    g = 0;
    while (start_times.size() == 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("f0_frame_started", start_times.size(), 1);
    repeat (39) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_exp.delete();
    last_rx = 8'h00;
    base_v  = rx_valid_seen;
    tick();
    check("midframe_rst_uart_tx", uart_tx, 1);
    check("midframe_rst_tx_ready", tx_ready, 1);
    check("midframe_rst_tx_busy", tx_busy, 0);
    check("midframe_rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    tick(200);
    check("midframe_rst_no_rx_valid", rx_valid_seen - base_v, 0);
    push_byte(8'h0F);
    wait_idle("post_reset_0f", 400);
    check("post_reset_rx_data", rx_data, 8'h0F);

    // Random bytes with random gaps (zero gaps exercise FIFO backpressure).
    for (int i = 0; i < 12; i++) begin
      push_byte(8'($urandom));
      tick($urandom_range(0, 220));
    end
    wait_idle("random", 8000);

    check("end_tx_queue_empty", tx_exp.size(), 0);
    check("end_rx_queue_empty", rx_exp.size(), 0);
    check("end_no_pending_err", err_pending, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
